// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the 14-bit PRBS generator/checker pair.
// Holds the word width, the feedback tap mask, the next-state function,
// a popcount helper and the checker FSM state type.
package prbs_pkg;

    localparam int PRBS_N = 14;

    // Feedback taps: bits 13, 4, 2 and 0.
    localparam logic [PRBS_N-1:0] PRBS_TAPS = 14'h2015;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_t;

    function automatic logic [PRBS_N-1:0] prbs_next(input logic [PRBS_N-1:0] s);
        return {^(s & PRBS_TAPS), s[PRBS_N-1:1]};
    endfunction

    function automatic logic [4:0] prbs_popcount(input logic [PRBS_N-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < PRBS_N; i++)
            c = c + 5'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// prbs_sat_cnt: saturating accumulator with synchronous clear.
// Ports: clk, rst_n (async, active-low), clr (sync clear, wins over en),
//        en (add amt this cycle), amt (AW-bit increment), cnt (W-bit result,
//        sticks at all-ones once the sum would overflow).
module prbs_sat_cnt #(
    parameter int W  = 16,
    parameter int AW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  cnt
);

    localparam int SW = (W > AW ? W : AW) + 1;

    logic [SW-1:0] sum;

    assign sum = SW'(cnt) + SW'(amt);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (sum > SW'({W{1'b1}})) ? '1 : sum[W-1:0];

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the 14-bit PRBS state bus.
// Hunts for a nonzero seed, verifies LOCK_CNT consecutive matches, then
// flywheels its own prediction and counts mismatching words.
// Ports: clk, rst_n (async, active-low), din_valid/din (received word),
//        clear_cnt (sync counter clear), locked, err_pulse, err_count,
//        bit_err_count (only with PRBS_CHK_BITERR_EN defined).
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N           = 14,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic [N-1:0]     din,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
`ifdef PRBS_CHK_BITERR_EN
    output logic [CNT_W-1:0] bit_err_count,
`endif
    output logic [CNT_W-1:0] err_count
);

    localparam logic [7:0] LOCK_V   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_V = 8'(UNLOCK_ERRS);

    chk_state_t  state_q, state_d;
    logic [N-1:0] pred_q, pred_d;
    logic [7:0]  match_q, match_d, miss_q, miss_d;
    logic        pulse_d, err_inc;

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        pulse_d = 1'b0;
        err_inc = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT:
                    if (din != '0) begin
                        pred_d  = prbs_next(din);
                        match_d = '0;
                        state_d = VERIFY;
                    end
                VERIFY:
                    if (din == pred_q) begin
                        pred_d  = prbs_next(din);
                        match_d = match_q + 8'd1;
                        if (match_q + 8'd1 == LOCK_V) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (din == '0) begin
                        state_d = HUNT;
                    end else begin
                        pred_d  = prbs_next(din);
                        match_d = '0;
                    end
                LOCKED: begin
                    // Flywheel: advance from our own prediction so a corrupted
                    // word cannot poison the following comparisons.
                    pred_d = prbs_next(pred_q);
                    if (din == pred_q) begin
                        miss_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        err_inc = 1'b1;
                        miss_d  = miss_q + 8'd1;
                        if (miss_q + 8'd1 == UNLOCK_V)
                            state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= HUNT;
            pred_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_pulse <= pulse_d;
        end

    assign locked = (state_q == LOCKED);

    prbs_sat_cnt #(.W(CNT_W), .AW(1)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_cnt),
        .en    (err_inc),
        .amt   (1'b1),
        .cnt   (err_count)
    );

`ifdef PRBS_CHK_BITERR_EN
    prbs_sat_cnt #(.W(CNT_W), .AW(5)) u_bit_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_cnt),
        .en    (err_inc),
        .amt   (prbs_popcount(din ^ pred_q)),
        .cnt   (bit_err_count)
    );
`endif

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Downstream consumer of the 14-bit PRBS generator bus.
- Receives one 14-bit LFSR state word per valid cycle and self-synchronises to the sequence.
- Once locked, flywheels its own prediction, then flags, counts and recovers from mismatches.
- Used in link/loopback self-test to qualify the data path between generator and checker.

Parameters:
- N, 14: word width. Taps are fixed for N=14; other values are unsupported.
- LOCK_CNT, 8: consecutive matching words needed in VERIFY to declare lock (1..255).
- UNLOCK_ERRS, 4: consecutive mismatching words in LOCKED that force re-hunt (1..255).
- CNT_W, 16: width of the error counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- din_valid  in  1  din is sampled on this cycle's rising edge.
- din  in  N  received PRBS state word.
- clear_cnt  in  1  synchronous clear of the error counters.
- locked  out  1  high while FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching word while LOCKED.
- err_count  out  CNT_W  saturating count of mismatching words while LOCKED.

Behaviour:
- Next-state function: next(s) = {fb, s[13:1]}, where fb = s[13]^s[4]^s[2]^s[0].
- Registered state: FSM, pred[N-1:0], match_cnt, miss_cnt, err_count, err_pulse.
- Reset values: FSM=HUNT; pred=0; all counters 0; locked=0; err_pulse=0; err_count=0.
- din_valid=0: all state holds; err_pulse drops to 0.
- HUNT, on valid din:
  - din==0 (illegal state): stay in HUNT.
  - Otherwise: pred<=next(din), match_cnt<=0, go to VERIFY.
- VERIFY, on valid din:
  - din==pred: match_cnt++ and pred<=next(din). If match_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt=0.
  - din!=pred: pred<=next(din) and match_cnt<=0 (re-seed); stay in VERIFY. A zero word in this case goes to HUNT instead.
- LOCKED, on valid din (flywheel):
  - pred<=next(pred) regardless of din, so a corrupted word does not propagate.
  - Match: miss_cnt<=0.
  - Mismatch: err_pulse<=1; err_count saturating-increments (stops at all-ones); miss_cnt++.
  - When miss_cnt reaches UNLOCK_ERRS: go to HUNT, locked drops.
- Timing:
  - locked and err_pulse are registered, visible the cycle after the deciding word is sampled.
  - From reset with contiguous valid words, word index LOCK_CNT (the 9th word at default) sets locked.
- clear_cnt has priority over a simultaneous increment: the result is 0. It does not affect FSM, pred or locked.
- Errors in HUNT or VERIFY are not counted.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). The checker re-hunts after release.

Optional Feature:
- Macro: PRBS_CHK_BITERR_EN.
- Defined:
  - Adds output bit_err_count (CNT_W wide, saturating).
  - Each mismatching word in LOCKED adds popcount(din ^ pred); the add saturates at all-ones.
  - Cleared by clear_cnt and by reset, same priority rules as err_count.
- Undefined: port and logic are absent. The rest of the behaviour is identical.

Decomposition:
- Package prbs_pkg holds:
  - PRBS_N = 14 and the tap constant.
  - The prbs_next() function, shared with the generator.
  - The FSM enum chk_state_t {HUNT, VERIFY, LOCKED}.
- One sub-module, prbs_sat_cnt: a parameterised saturating accumulator with clear and increment-amount inputs. It is instantiated for err_count and, with the macro, for bit_err_count.

Test Plan:
- Lock from reset: feed 0x0001, 0x2000, 0x3000, 0x3800, ... contiguously -> locked=1 the cycle after word 8 is sampled; err_count=0.
- Single-bit error while locked: XOR bit 0 into one word -> err_pulse high exactly 1 cycle; err_count=1; locked stays 1; following clean words match. With macro: bit_err_count=1.
- Loss of lock: 4 consecutive corrupted words while locked -> err_count=4, locked=0 the cycle after the 4th; the checker then relocks on 9 clean words.
- Valid gaps and zero word: toggle din_valid 1/0 with a clean stream -> lock is still reached after 9 valid words. A 0x0000 word while in HUNT -> checker stays in HUNT.
- Clear collision and saturation: clear_cnt in the same cycle as an error -> err_count=0. With CNT_W=4, 20 errors -> err_count=15.
- Reset mid-lock: drop rst_n asynchronously while locked -> locked=0, err_count=0 with no clock edge; relock after release.
